onewire_master_param: RTL and testbench

Parametrised 1-Wire bus master. It generates reset/presence, write and read time slots on an open-drain DQ line for a frame of DATA_BYTES data bytes plus one Dallas CRC-8 byte. It is the next generation of the fixed 56-bit onewire master: data width, bus timing and transfer direction are configurable, and it adds a read mode with a CRC check and presence detection. It sits between the command logic and the DQ pad buffer.

---
 rtl/onewire_pkg.sv | 58 +++++
 rtl/onewire_crc8.sv | 36 +++
 rtl/onewire_master_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_onewire_master_param.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_pkg
//  Description : Shared definitions for the parametrised 1-Wire master.
//                FSM state encoding, default bus timing (in clk cycles),
//                the Dallas/Maxim CRC-8 step function and the
//                start-to-done latency formula.
//  Revision    : 1.0  initial release
// ============================================================================
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_LOW   = 3'd1,
        ST_RST_HIGH  = 3'd2,
        ST_SLOT_LOW  = 3'd3,
        ST_SLOT_HIGH = 3'd4,
        ST_REC       = 3'd5,
        ST_FINISH    = 3'd6
    } ow_state_e;

    // Default timing, all in clk cycles.
    localparam int DEF_DATA_BYTES = 7;
    localparam int DEF_T_RSTL     = 480;
    localparam int DEF_T_RSTH     = 480;
    localparam int DEF_T_PDS      = 70;
    localparam int DEF_T_SLOT     = 60;
    localparam int DEF_T_LOW1     = 6;
    localparam int DEF_T_LOW0     = 60;
    localparam int DEF_T_RDS      = 15;
    localparam int DEF_T_REC      = 5;

    // Reflected form of x^8 + x^5 + x^4 + 1.
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

    // Number of clk edges from the edge that accepts i_start to the edge
    // after which o_done is high. Each state lasts exactly its nominal
    // count, FINISH adds one cycle.
    function automatic int done_latency(input int data_bytes,
                                        input int t_rstl,
                                        input int t_rsth,
                                        input int t_slot,
                                        input int t_rec,
                                        input logic presence);
        if (presence)
            return t_rstl + t_rsth + (8 * data_bytes + 8) * (t_slot + t_rec) + 1;
        else
            return t_rstl + t_rsth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onewire_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_crc8
//  Description : Serial Dallas/Maxim CRC-8 register (reflected poly 0x8C,
//                init 0x00), one bit per enabled clock.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-low reset
//                i_clear  - synchronous clear to 0x00 (wins over i_en)
//                i_en     - advance the CRC by one bit
//                i_bit    - data bit to absorb
//                o_crc    - current CRC value
//  Revision    : 1.0  initial release
// ============================================================================
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_crc <= 8'h00;
        end else if (i_clear) begin
            o_crc <= 8'h00;
        end else if (i_en) begin
            o_crc <= crc8_step(o_crc, i_bit);
        end
    end

endmodule
`default_nettype wire

// File: rtl/onewire_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_master_param
//  Description : Parametrised 1-Wire bus master. Issues reset/presence,
//                then DATA_BYTES*8 + 8 write or read slots on an
//                open-drain DQ line. Write frames append the CRC-8 of the
//                payload; read frames check the CRC residual.
//  Ports       : clk           - system clock
//                reset         - asynchronous active-low reset
//                i_start       - start request, sampled only in IDLE
//                i_mode        - 0 write frame, 1 read frame
//                i_tx_data     - payload, byte 0 in [7:0], sent LSB first
//                i_dq          - DQ pad input (asynchronous)
//                o_dq_oe       - 1 pulls DQ low
//                o_busy        - frame in progress
//                o_done        - one-cycle completion pulse
//                o_rx_data     - received payload (read mode)
//                o_crc_err     - read CRC mismatch, held until next start
//                o_no_presence - no presence pulse, held until next start
//  Revision    : 1.0  initial release
// ============================================================================
module onewire_master_param
    import onewire_pkg::*;
#(
    parameter int DATA_BYTES = DEF_DATA_BYTES,
    parameter int T_RSTL     = DEF_T_RSTL,
    parameter int T_RSTH     = DEF_T_RSTH,
    parameter int T_PDS      = DEF_T_PDS,
    parameter int T_SLOT     = DEF_T_SLOT,
    parameter int T_LOW1     = DEF_T_LOW1,
    parameter int T_LOW0     = DEF_T_LOW0,
    parameter int T_RDS      = DEF_T_RDS,
    parameter int T_REC      = DEF_T_REC,
    parameter int DATA_W     = 8 * DATA_BYTES
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_dq,
    output logic              o_dq_oe,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_crc_err,
    output logic              o_no_presence
);

    localparam int FRAME_BITS = DATA_W + 8;
    localparam int IDX_W      = $clog2(FRAME_BITS + 1);
    localparam int T_MAX_A    = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
    localparam int T_MAX_B    = (T_SLOT > T_REC)  ? T_SLOT : T_REC;
    localparam int T_MAX_C    = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX      = (T_MAX_C > T_PDS) ? T_MAX_C : T_PDS;
    localparam int CNT_W      = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_rstl_end  = CNT_W'(T_RSTL - 1);
    localparam logic [CNT_W-1:0] c_rsth_end  = CNT_W'(T_RSTH - 1);
    localparam logic [CNT_W-1:0] c_pds       = CNT_W'(T_PDS);
    localparam logic [CNT_W-1:0] c_slot_end  = CNT_W'(T_SLOT - 1);
    localparam logic [CNT_W-1:0] c_low0_end  = CNT_W'(T_LOW0 - 1);
    localparam logic [CNT_W-1:0] c_low1_end  = CNT_W'(T_LOW1 - 1);
    localparam logic [CNT_W-1:0] c_rds       = CNT_W'(T_RDS);
    localparam logic [CNT_W-1:0] c_rec_end   = CNT_W'(T_REC - 1);
    localparam logic [IDX_W-1:0] c_data_w    = IDX_W'(DATA_W);
    localparam logic [IDX_W-1:0] c_frame_end = IDX_W'(FRAME_BITS);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    ow_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_dq_meta;
    logic              r_dq_sync;
    logic              r_mode;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_cur_bit;   // bit being sent, or bit just sampled
    logic              r_long_low;  // current slot uses T_LOW0
    logic              r_presence;

    // ------------------------------------------------------------------
    // Slot strobes
    // ------------------------------------------------------------------
    logic [7:0] w_crc;
    logic       w_in_slot;
    logic       w_slot_end;
    logic       w_low_end;
    logic       w_sample;
    logic       w_next_bit;
    logic       w_crc_clr;

    assign w_in_slot  = (r_state == ST_SLOT_LOW) || (r_state == ST_SLOT_HIGH);
    assign w_slot_end = w_in_slot && (r_cnt == c_slot_end);
    assign w_low_end  = r_long_low ? (r_cnt == c_low0_end) : (r_cnt == c_low1_end);
    assign w_sample   = r_mode && w_in_slot && (r_cnt == c_rds);
    assign w_crc_clr  = (r_state == ST_IDLE) && i_start;

    // During the CRC byte the register's LSB is sent and also fed back:
    // fb = crc[0]^crc[0] = 0, so the CRC simply shifts itself out and the
    // residual ends at zero.
    assign w_next_bit = (r_bit_idx < c_data_w) ? r_tx[0] : w_crc[0];

    onewire_crc8 u_crc (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_crc_clr),
        .i_en    (w_slot_end),
        .i_bit   (r_cur_bit),
        .o_crc   (w_crc)
    );

    // ------------------------------------------------------------------
    // DQ synchroniser; the idle bus is pulled up, so it resets high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dq_meta <= 1'b1;
            r_dq_sync <= 1'b1;
        end else begin
            r_dq_meta <= i_dq;
            r_dq_sync <= r_dq_meta;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM. o_dq_oe is the registered image of "state drives low", so
    // every low phase appears on the pin one cycle after the state is
    // entered and lasts exactly as many cycles as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_mode        <= 1'b0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_cur_bit     <= 1'b0;
            r_long_low    <= 1'b0;
            r_presence    <= 1'b0;
            o_dq_oe       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_rx_data     <= '0;
            o_crc_err     <= 1'b0;
            o_no_presence <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_dq_oe <= (r_state == ST_RST_LOW) || (r_state == ST_SLOT_LOW);

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mode        <= i_mode;
                        r_tx          <= i_tx_data;
                        r_rx          <= '0;
                        r_cnt         <= '0;
                        r_bit_idx     <= '0;
                        r_presence    <= 1'b0;
                        o_crc_err     <= 1'b0;
                        o_no_presence <= 1'b0;
                        o_busy        <= 1'b1;
                        r_state       <= ST_RST_LOW;
                    end
                end

                ST_RST_LOW: begin
                    if (r_cnt == c_rstl_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_RST_HIGH;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                ST_RST_HIGH: begin
                    if (r_cnt == c_pds) begin
                        r_presence <= ~r_dq_sync;
                    end
                    if (r_cnt == c_rsth_end) begin
                        r_cnt <= '0;
                        if (r_presence) begin
                            r_cur_bit  <= w_next_bit;
                            r_long_low <= ~r_mode & ~w_next_bit;
                            r_state    <= ST_SLOT_LOW;
                        end else begin
                            o_no_presence <= 1'b1;
                            r_state       <= ST_FINISH;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                // The slot counter runs across both halves of the slot so
                // the slot length is independent of the low time; when
                // T_LOW0 == T_SLOT a write-0 slot never enters SLOT_HIGH.
                ST_SLOT_LOW, ST_SLOT_HIGH: begin
                    if (w_sample) begin
                        r_cur_bit <= r_dq_sync;
                    end
                    if (w_slot_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + c_idx_one;
                        if (!r_mode) begin
                            r_tx <= r_tx >> 1;
                        end else if (r_bit_idx < c_data_w) begin
                            r_rx <= {r_cur_bit, r_rx[DATA_W-1:1]};
                        end
                        r_state <= ST_REC;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if ((r_state == ST_SLOT_LOW) && w_low_end) begin
                            r_state <= ST_SLOT_HIGH;
                        end
                    end
                end

                ST_REC: begin
                    if (r_cnt == c_rec_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_frame_end) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_cur_bit  <= w_next_bit;
                            r_long_low <= ~r_mode & ~w_next_bit;
                            r_state    <= ST_SLOT_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                ST_FINISH: begin
                    o_done    <= 1'b1;
                    o_busy    <= 1'b0;
                    o_rx_data <= r_rx;
                    o_crc_err <= r_mode && (w_crc != 8'h00);
                    r_cnt     <= '0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onewire_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onewire_master_param
//  Description : Directed self-checking bench for onewire_master_param
//                (DATA_BYTES = 9, default timing) with a behavioural
//                1-Wire slave that answers presence, decodes written slots
//                and returns read bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_onewire_master_param;

    localparam int DATA_BYTES = 9;
    localparam int DATA_W     = 72;
    localparam logic [71:0] MSG = 72'h393837363534333231;
    localparam int LAT_FULL   = 6161;  // 480 + 480 + 80*65 + 1
    localparam int LAT_NOPRES = 961;   // 480 + 480 + 1

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_start = 1'b0;
    logic              i_mode = 1'b0;
    logic [DATA_W-1:0] i_tx_data = '0;
    logic              dq;
    logic              o_dq_oe;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_crc_err;
    logic              o_no_presence;

    int n_checks = 0;
    int n_fail   = 0;

    // slave controls (written by the stimulus only)
    logic        slv_clr = 1'b0;
    logic        slv_present = 1'b1;
    logic        slv_read = 1'b0;
    logic [79:0] slv_rd_bits = '0;

    // slave state (written by the slave process only)
    logic        slave_pull = 1'b0;
    logic        prev_oe = 1'b0;
    logic        in_frame = 1'b0;
    int          lowcnt = 0;
    int          pres_dly = 0;
    int          pull_cnt = 0;
    int          rd_idx = 0;
    int          n_slots = 0;
    logic [79:0] wr_bits = '0;
    int          wr_len [80];

    int done_cnt = 0;

    always #5 clk = ~clk;

    assign dq = !(o_dq_oe || slave_pull);

    onewire_master_param #(.DATA_BYTES(DATA_BYTES)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_mode        (i_mode),
        .i_tx_data     (i_tx_data),
        .i_dq          (dq),
        .o_dq_oe       (o_dq_oe),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rx_data     (o_rx_data),
        .o_crc_err     (o_crc_err),
        .o_no_presence (o_no_presence)
    );

    always @(negedge clk) begin
        if (o_done) done_cnt++;
    end

    // Behavioural slave: low pulses >= 300 cycles are bus resets, shorter
    // ones are slots (< 30 cycles decodes as 1).
    always @(negedge clk) begin
        if (slv_clr) begin
            lowcnt = 0; pres_dly = 0; pull_cnt = 0; rd_idx = 0; n_slots = 0;
            in_frame = 1'b0; prev_oe = 1'b0; wr_bits = '0;
            for (int i = 0; i < 80; i++) wr_len[i] = 0;
        end else begin
            if (pull_cnt > 0) pull_cnt--;
            if (pres_dly > 0) begin
                pres_dly--;
                if (pres_dly == 0) pull_cnt = 100;
            end
            if (o_dq_oe) begin
                if (!prev_oe && in_frame && slv_read && rd_idx < 80) begin
                    if (!slv_rd_bits[rd_idx]) pull_cnt = 30;
                    rd_idx++;
                end
                lowcnt++;
            end else if (lowcnt > 0) begin
                if (lowcnt >= 300) begin
                    in_frame = 1'b1;
                    if (slv_present) pres_dly = 15;
                end else begin
                    if (n_slots < 80) begin
                        wr_bits[n_slots] = (lowcnt < 30);
                        wr_len[n_slots]  = lowcnt;
                    end
                    n_slots++;
                end
                lowcnt = 0;
            end
            prev_oe = o_dq_oe;
        end
        slave_pull = (pull_cnt > 0);
    end

    task automatic check_val(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_slave();
        @(posedge clk); #2 slv_clr = 1'b1;
        @(posedge clk); #2 slv_clr = 1'b0;
    endtask

    // Runs one frame. lat = edges from acceptance until o_done seen high
    // (-1 if it never came); ndone = o_done pulses during the frame.
    // mid_at > 0 pulses i_start once at that cycle of the frame.
    task automatic run_frame(input logic mode, input logic [71:0] data, input int mid_at,
                             output int lat, output int ndone);
        int d0;
        int cyc;
        lat = -1;
        clear_slave();
        d0 = done_cnt;
        @(negedge clk);
        i_mode = mode; i_tx_data = data; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check_val("busy_at_accept", 80'(o_busy), 80'(1));
        check_val("oe_at_edge_n", 80'(o_dq_oe), 80'(0));
        @(posedge clk); #1;
        check_val("oe_at_edge_n1", 80'(o_dq_oe), 80'(1));
        cyc = 1;
        for (int k = 0; k < 10000; k++) begin
            if (o_done) begin
                lat = cyc;
                break;
            end
            i_start = (cyc == mid_at);
            @(posedge clk); cyc++; #1;
        end
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ndone = done_cnt - d0;
    endtask

    initial begin
        int lat;
        int nd;
        int bad;
        int d0;
        int w;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_oe", 80'(o_dq_oe), 80'(0));
        check_val("rst_busy", 80'(o_busy), 80'(0));
        check_val("rst_done", 80'(o_done), 80'(0));
        check_val("rst_rx", 80'(o_rx_data), 80'(0));
        check_val("rst_crc_err", 80'(o_crc_err), 80'(0));
        check_val("rst_no_pres", 80'(o_no_presence), 80'(0));
        @(negedge clk) reset = 1'b1;

        // write frame "123456789"
        slv_present = 1'b1; slv_read = 1'b0;
        run_frame(1'b0, MSG, 0, lat, nd);
        check_val("wr_latency", 80'(lat), 80'(LAT_FULL));
        check_val("wr_slots", 80'(n_slots), 80'(80));
        check_val("wr_payload", 80'(wr_bits[71:0]), 80'(MSG));
        check_val("wr_crc_byte", 80'(wr_bits[79:72]), 80'(8'hA1));
        check_val("wr_done_once", 80'(nd), 80'(1));
        check_val("wr_crc_err", 80'(o_crc_err), 80'(0));
        check_val("wr_no_pres", 80'(o_no_presence), 80'(0));
        check_val("wr_busy_after", 80'(o_busy), 80'(0));
        bad = 0;
        for (int i = 0; i < 80; i++)
            if (wr_len[i] != (wr_bits[i] ? 6 : 60)) bad++;
        check_val("wr_low_times", 80'(bad), 80'(0));

        // read frame, good CRC
        slv_read = 1'b1;
        slv_rd_bits = {8'hA1, MSG};
        run_frame(1'b1, 72'h0, 0, lat, nd);
        check_val("rd_latency", 80'(lat), 80'(LAT_FULL));
        check_val("rd_data", 80'(o_rx_data), 80'(MSG));
        check_val("rd_crc_err", 80'(o_crc_err), 80'(0));
        check_val("rd_done_once", 80'(nd), 80'(1));

        // read frame, corrupted CRC byte
        slv_rd_bits = {8'hA0, MSG};
        run_frame(1'b1, 72'h0, 0, lat, nd);
        check_val("rdbad_data", 80'(o_rx_data), 80'(MSG));
        check_val("rdbad_crc_err", 80'(o_crc_err), 80'(1));

        // no slave present
        slv_read = 1'b0; slv_present = 1'b0;
        run_frame(1'b0, MSG, 0, lat, nd);
        check_val("np_latency", 80'(lat), 80'(LAT_NOPRES));
        check_val("np_flag", 80'(o_no_presence), 80'(1));
        check_val("np_slots", 80'(n_slots), 80'(0));
        check_val("np_done_once", 80'(nd), 80'(1));
        check_val("np_crc_err", 80'(o_crc_err), 80'(0));

        // all-zero write with a stray start mid-frame
        slv_present = 1'b1;
        run_frame(1'b0, 72'h0, 2000, lat, nd);
        check_val("zero_latency", 80'(lat), 80'(LAT_FULL));
        check_val("zero_no_pres_cleared", 80'(o_no_presence), 80'(0));
        check_val("zero_slots", 80'(n_slots), 80'(80));
        check_val("zero_crc_byte", 80'(wr_bits[79:72]), 80'(8'h00));
        bad = 0;
        for (int i = 0; i < 72; i++)
            if (wr_len[i] != 60) bad++;
        check_val("zero_low_t_low0", 80'(bad), 80'(0));
        check_val("zero_done_once", 80'(nd), 80'(1));
        d0 = done_cnt;
        repeat (50) @(posedge clk);
        #1;
        check_val("zero_no_restart", 80'(o_busy), 80'(0));
        check_val("zero_no_extra_done", 80'(done_cnt - d0), 80'(0));

        // asynchronous reset in the middle of a slot
        clear_slave();
        @(negedge clk);
        i_mode = 1'b0; i_tx_data = MSG; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        w = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            w++;
            if (w > 1000 && o_dq_oe) break;
        end
        check_val("pre_rst_oe_high", 80'(o_dq_oe), 80'(1));
        d0 = done_cnt;
        #3 reset = 1'b0;
        #1;
        check_val("async_rst_oe", 80'(o_dq_oe), 80'(0));
        check_val("async_rst_busy", 80'(o_busy), 80'(0));
        check_val("async_rst_done", 80'(o_done), 80'(0));
        repeat (20) @(posedge clk);
        #1;
        check_val("async_rst_no_done", 80'(done_cnt - d0), 80'(0));
        check_val("async_rst_oe_held", 80'(o_dq_oe), 80'(0));
        @(negedge clk) reset = 1'b1;

        // clean frame after reset
        run_frame(1'b0, MSG, 0, lat, nd);
        check_val("post_rst_latency", 80'(lat), 80'(LAT_FULL));
        check_val("post_rst_payload", 80'(wr_bits[71:0]), 80'(MSG));
        check_val("post_rst_crc_byte", 80'(wr_bits[79:72]), 80'(8'hA1));
        check_val("post_rst_done_once", 80'(nd), 80'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
